// File: rtl/bus_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin bus arbiter.
// Also holds the rotating-priority pick function used by the FSM.
package bus_arbiter_4_pkg;

  localparam int NUM_REQ          = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [1:0]         ptr);
    pick_t      res;
    logic [1:0] cand;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_4_mux.sv
// NAND-built 4:1 bus multiplexer; s1 picks within a pair, s0 picks the pair.
// Wider or narrower buses replicate the same per-bit NAND cell.
module mux_4_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y
);

  logic s0_n;
  logic s1_n;

  assign s0_n = ~(s0 & s0);
  assign s1_n = ~(s1 & s1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic lo_a, lo_b, lo;
      logic hi_a, hi_b, hi;
      logic y_a, y_b;

      assign lo_a = ~(d0[gi] & s1_n);
      assign lo_b = ~(d1[gi] & s1);
      assign lo   = ~(lo_a & lo_b);

      assign hi_a = ~(d2[gi] & s1_n);
      assign hi_b = ~(d3[gi] & s1);
      assign hi   = ~(hi_a & hi_b);

      assign y_a   = ~(lo & s0_n);
      assign y_b   = ~(hi & s0);
      assign y[gi] = ~(y_a & y_b);
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter with a hold limit, driving the select lines of a shared
// 4:1 bus mux from its registered grant index.
module bus_arbiter_4
  import bus_arbiter_4_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [WIDTH-1:0]     d0,
  input  logic [WIDTH-1:0]     d1,
  input  logic [WIDTH-1:0]     d2,
  input  logic [WIDTH-1:0]     d3,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [1:0]           grant_id,
  output logic                 bus_valid,
  output logic [WIDTH-1:0]     y
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state_reg,    state_next;
  logic [NUM_REQ-1:0]  gnt_reg,      gnt_next;
  logic [1:0]          grant_id_reg, grant_id_next;
  logic [1:0]          ptr_reg,      ptr_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;

  logic [NUM_REQ-1:0]  others;
  pick_t               pick_all;
  pick_t               pick_others;
  logic                do_grant;
  logic [1:0]          new_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      grant_id_reg <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      grant_id_reg <= grant_id_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // In GRANT, gnt_reg is one-hot on the owner, so others excludes only it.
  assign others      = req & ~gnt_reg;
  assign pick_all    = rr_pick(req, ptr_reg);
  assign pick_others = rr_pick(others, ptr_reg);

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    grant_id_next = grant_id_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    do_grant      = 1'b0;
    new_id        = '0;

    case (state_reg)
      IDLE: begin
        if (pick_all.found) begin
          do_grant = 1'b1;
          new_id   = pick_all.idx;
        end
      end
      GRANT: begin
        if (!req[grant_id_reg]) begin
          if (pick_others.found) begin
            do_grant = 1'b1;
            new_id   = pick_others.idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (pick_others.found && (hold_cnt_reg == HOLD_LAST)) begin
          do_grant = 1'b1;
          new_id   = pick_others.idx;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    if (do_grant) begin
      state_next    = GRANT;
      gnt_next      = NUM_REQ'(1) << new_id;
      grant_id_next = new_id;
      ptr_next      = new_id + 2'd1;
      hold_cnt_next = '0;
    end
  end

  assign gnt       = gnt_reg;
  assign grant_id  = grant_id_reg;
  assign bus_valid = (state_reg == GRANT);

  mux_4_16 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s0 (grant_id_reg[1]),
    .s1 (grant_id_reg[0]),
    .y  (y)
  );

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Scoreboard bench for bus_arbiter_4: stimulus pushes expected bus state from a
// tenure-counting reference model; a monitor pops and compares after each edge.
module tb_bus_arbiter_4;

  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req   = '0;
  logic [WIDTH-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]       gnt;
  logic [1:0]       grant_id;
  logic             bus_valid;
  logic [WIDTH-1:0] y;

  always #5 clk = ~clk;

  bus_arbiter_4 #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .gnt       (gnt),
    .grant_id  (grant_id),
    .bus_valid (bus_valid),
    .y         (y)
  );

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       id;
    logic             valid;
    logic [WIDTH-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: owner (-1 = none), rotation pointer, cycles owned so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_owned = 0;
  int m_last  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int excl);
    int c;
    for (int j = 0; j < 4; j++) begin
      c = (m_ptr + j) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_grant(input int k);
    m_owner = k;
    m_last  = k;
    m_ptr   = (k + 1) % 4;
    m_owned = 1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_owned = 0;
    m_last  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int k;
    if (m_owner < 0) begin
      k = pick(r, -1);
      if (k >= 0) model_grant(k);
    end else if (!r[m_owner]) begin
      k = pick(r, -1);
      if (k >= 0) model_grant(k);
      else m_owner = -1;
    end else begin
      k = pick(r, m_owner);
      if (m_owned >= MAX_HOLD && k >= 0) model_grant(k);
      else m_owned++;
    end
  endtask

  // Drive inputs now and queue what the bus must show after the next edge.
  task automatic apply(input logic [3:0] r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e);
    exp_t x;
    req = r;
    d0  = a;
    d1  = b;
    d2  = c;
    d3  = e;
    model_edge(r);
    x.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    x.id    = 2'(m_last);
    x.valid = (m_owner >= 0);
    case (m_last)
      0:       x.y = a;
      1:       x.y = b;
      2:       x.y = c;
      default: x.y = e;
    endcase
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [3:0] r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e);
    @(negedge clk);
    apply(r, a, b, c, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'(gnt),       32'h0);
    check({tag, "_valid"}, 32'(bus_valid), 32'h0);
    check({tag, "_id"},    32'(grant_id),  32'h0);
    check({tag, "_y"},     32'(y),         32'(d0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",       32'(gnt),       32'(e.gnt));
        check("grant_id",  32'(grant_id),  32'(e.id));
        check("bus_valid", 32'(bus_valid), 32'(e.valid));
        check("y",         32'(y),         32'(e.y));
      end
    end
  end

  initial begin : stimulus
    logic [3:0]       rq;
    logic [WIDTH-1:0] ra, rb, rc, rd;

    d0 = 16'hA5A5; d1 = 16'hBEEF; d2 = 16'h2222; d3 = 16'h3333;
    #2;
    check_reset_outputs("por");

    // Single requester from IDLE keeps the bus well past the hold limit.
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0010, 16'hA5A5, 16'hBEEF, 16'h2222, 16'h3333);
    repeat (22) step(4'b0010, 16'hA5A5, 16'hBEEF, 16'h2222, 16'h3333);

    // Release handoffs 1 -> 0 -> 3 with no idle bubble.
    repeat (3) step(4'b0001, 16'h0A0A, 16'hBEEF, 16'h2222, 16'hCAFE);
    repeat (3) step(4'b1000, 16'h0A0A, 16'hBEEF, 16'h2222, 16'hCAFE);

    // Owner 2 releases to IDLE; 0101 then goes to 0 via pointer wrap.
    repeat (3) step(4'b0100, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
    step(4'b0000, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
    repeat (4) step(4'b0101, 16'h1000, 16'h1001, 16'h1002, 16'h1003);

    // Asynchronous reset in the middle of a grant.
    repeat (2) step(4'b0000, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
    repeat (3) step(4'b0100, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0100, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
    repeat (2) step(4'b0100, 16'h4444, 16'h5555, 16'h6666, 16'h7777);

    // Two requesters held: alternating MAX_HOLD-cycle tenures.
    repeat (36) step(4'b0011, 16'h00AA, 16'h11BB, 16'h22CC, 16'h33DD);

    // All four held: strict rotation.
    repeat (70) step(4'b1111, 16'h0000, 16'h1111, 16'h2222, 16'h3333);

    // Random level requests that persist for a while, with random data.
    rq = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      rd = 16'($urandom);
      step(rq, ra, rb, rc, rd);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
